// File: rtl/ntt_out_ctrl_pkg.sv
// rtl/ntt_out_ctrl_pkg.sv - shared NTT parameters, FSM encoding and select helper
package ntt_out_ctrl_pkg;

   localparam int NTT_ADDR_W   = 6;
   localparam int NTT_STAGES   = 8;
   localparam int NTT_PIPE_LAT = 13;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } ntt_state_t;

   // one 2-bit select per bank output lane
   typedef logic [3:0][1:0] sel_vec_t;

   // lane k picks bank k XOR {stage lsb, address lsb}; XOR by a constant keeps it a permutation
   function automatic sel_vec_t sel_word(input logic stage_lsb, input logic addr_lsb);
      sel_vec_t v;
      for (int k = 0; k < 4; k++) begin
         v[k] = 2'(k) ^ {stage_lsb, addr_lsb};
      end
      return v;
   endfunction

endpackage

// File: rtl/ntt_out_ctrl_shift_13.sv
// rtl/ntt_out_ctrl_shift_13.sv - fixed-latency resettable delay line matching the network select delay
module ntt_out_ctrl_shift_13
#(
   parameter int DATA_W = 7,
   parameter int DEPTH  = 13
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DEPTH-1:0][DATA_W-1:0] pipe;

   // shift one slot per cycle; reset flushes every slot so no stale write survives
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe <= '0;
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_out_ctrl.sv
// rtl/ntt_out_ctrl.sv - NTT output-stage read/write address and select sequencer
module ntt_out_ctrl
   import ntt_out_ctrl_pkg::*;
#(
   parameter int ADDR_W   = NTT_ADDR_W,
   parameter int STAGES   = NTT_STAGES,
   parameter int PIPE_LAT = NTT_PIPE_LAT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [2:0]        stage,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [1:0]        sel_a_0,
   output logic [1:0]        sel_a_1,
   output logic [1:0]        sel_a_2,
   output logic [1:0]        sel_a_3,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr
);

   localparam int                CNT_W      = $clog2(PIPE_LAT + 1);
   localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(PIPE_LAT - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
   localparam logic [2:0]        LAST_STAGE = 3'(STAGES - 1);

   ntt_state_t       state;
   logic [CNT_W-1:0] gap_cnt;
   sel_vec_t         sel_q;
   logic [ADDR_W:0]  wr_bus;

   // sequencer: one burst of reads per stage, a pipeline-length gap between stages, then drain
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         stage   <= 3'd0;
         rd_addr <= '0;
         rd_en   <= 1'b0;
         sel_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         gap_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // the done cycle is still IDLE; a start seen there is dropped
               if (start && !done) begin
                  state   <= ST_RUN;
                  stage   <= 3'd0;
                  rd_addr <= '0;
                  rd_en   <= 1'b1;
                  sel_q   <= sel_word(1'b0, 1'b0);
                  busy    <= 1'b1;
               end
            end
            ST_RUN: begin
               if (rd_addr == LAST_ADDR) begin
                  rd_en   <= 1'b0;
                  sel_q   <= '0;
                  gap_cnt <= '0;
                  state   <= (stage == LAST_STAGE) ? ST_DRAIN : ST_WAIT;
               end else begin
                  rd_addr <= rd_addr + ADDR_W'(1);
                  sel_q   <= sel_word(stage[0], ~rd_addr[0]);
               end
            end
            ST_WAIT: begin
               // hold off the next stage until the last write of this one has landed
               if (gap_cnt == LAST_CNT) begin
                  state   <= ST_RUN;
                  stage   <= stage + 3'd1;
                  rd_addr <= '0;
                  rd_en   <= 1'b1;
                  sel_q   <= sel_word(~stage[0], 1'b0);
               end else begin
                  gap_cnt <= gap_cnt + CNT_W'(1);
               end
            end
            ST_DRAIN: begin
               if (gap_cnt == LAST_CNT) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               rd_en <= 1'b0;
               sel_q <= '0;
            end
         endcase
      end
   end

   assign sel_a_0 = sel_q[0];
   assign sel_a_1 = sel_q[1];
   assign sel_a_2 = sel_q[2];
   assign sel_a_3 = sel_q[3];

   ntt_out_ctrl_shift_13 #(
      .DATA_W (ADDR_W + 1),
      .DEPTH  (PIPE_LAT)
   ) u_wr_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({rd_en, rd_addr}),
      .dout (wr_bus)
   );

   assign {wr_en, wr_addr} = wr_bus;

endmodule

// File: tb/tb_ntt_out_ctrl.sv
// tb/tb_ntt_out_ctrl.sv - scoreboard bench for the NTT output sequencer
module tb_ntt_out_ctrl;

   localparam int N       = 64;
   localparam int LAT     = 13;
   localparam int NSTG    = 8;
   localparam int PERIOD  = N + LAT;
   localparam int LAST_RD = PERIOD * (NSTG - 1) + N - 1;
   localparam int FULL    = LAST_RD + LAT + 2;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       rd_en;
      logic [5:0] rd_addr;
      logic [2:0] stage;
      logic [1:0] s0;
      logic [1:0] s1;
      logic [1:0] s2;
      logic [1:0] s3;
      logic       wr_en;
      logic [5:0] wr_addr;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy, done, rd_en, wr_en;
   logic [2:0] stage;
   logic [5:0] rd_addr, wr_addr;
   logic [1:0] sel_a_0, sel_a_1, sel_a_2, sel_a_3;

   int   errors = 0;
   int   checks = 0;
   obs_t obs;
   obs_t exp_q[$];

   always #5 clk = ~clk;

   assign obs = {busy, done, rd_en, rd_addr, stage, sel_a_0, sel_a_1, sel_a_2, sel_a_3, wr_en, wr_addr};

   ntt_out_ctrl #(.ADDR_W(6), .STAGES(NSTG), .PIPE_LAT(LAT)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .stage   (stage),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .sel_a_0 (sel_a_0),
      .sel_a_1 (sel_a_1),
      .sel_a_2 (sel_a_2),
      .sel_a_3 (sel_a_3),
      .wr_en   (wr_en),
      .wr_addr (wr_addr)
   );

   function automatic void rd_model(input int o, output logic en, output logic [5:0] a, output logic [2:0] s);
      if (o > LAST_RD) begin
         en = 1'b0; a = 6'd63; s = 3'(NSTG - 1);
      end else begin
         s = 3'(o / PERIOD);
         if ((o % PERIOD) < N) begin
            en = 1'b1; a = 6'(o % PERIOD);
         end else begin
            en = 1'b0; a = 6'd63;
         end
      end
   endfunction

   function automatic obs_t model_at(input int o, input logic [5:0] prev);
      obs_t e;
      logic en;
      logic [5:0] a;
      logic [2:0] s;
      logic [1:0] m;
      e = '0;
      rd_model(o, en, a, s);
      e.rd_en = en; e.rd_addr = a; e.stage = s;
      if (en) begin
         m = {s[0], a[0]};
         e.s0 = m; e.s1 = 2'd1 ^ m; e.s2 = 2'd2 ^ m; e.s3 = 2'd3 ^ m;
      end
      e.busy = (o <= LAST_RD + LAT);
      e.done = (o == LAST_RD + LAT + 1);
      if (o >= LAT) begin
         rd_model(o - LAT, en, a, s);
         e.wr_en = en; e.wr_addr = a;
      end else begin
         e.wr_addr = prev;
      end
      return e;
   endfunction

   task automatic run_xfer(input string name, input logic [5:0] prev, input bit keep_start, input int n_cyc);
      obs_t e;
      logic [3:0] m;
      int rd_cnt, wr_cnt, done_cnt, o;
      rd_cnt = 0; wr_cnt = 0; done_cnt = 0; o = 0;
      for (int i = 0; i < n_cyc; i++) exp_q.push_back(model_at(i, prev));
      start = 1'b1;
      @(posedge clk);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         if (!keep_start) start = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL %s cycle o=%0d got=%h exp=%h", name, o, obs, e);
         end
         if (rd_en === 1'b1) begin
            rd_cnt++;
            m = '0;
            m[sel_a_0] = 1'b1; m[sel_a_1] = 1'b1; m[sel_a_2] = 1'b1; m[sel_a_3] = 1'b1;
            checks++;
            if (m !== 4'hf) begin
               errors++;
               $display("FAIL %s sel_distinct o=%0d got=%b exp=1111", name, o, m);
            end
         end
         if (wr_en === 1'b1) wr_cnt++;
         if (done === 1'b1) done_cnt++;
         o++;
      end
      if (n_cyc == FULL) begin
         checks += 3;
         if (rd_cnt != N * NSTG) begin errors++; $display("FAIL %s read_count got=%0d exp=%0d", name, rd_cnt, N * NSTG); end
         if (wr_cnt != N * NSTG) begin errors++; $display("FAIL %s write_count got=%0d exp=%0d", name, wr_cnt, N * NSTG); end
         if (done_cnt != 1) begin errors++; $display("FAIL %s done_count got=%0d exp=1", name, done_cnt); end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_state got=%h exp=0", obs); end
      start = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_with_start got=%h exp=0", obs); end
      start = 1'b0; rst = 1'b0;
      repeat (LAT + 2) @(negedge clk);
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_idle got=%h exp=0", obs); end
   endtask

   task automatic test_idle_hold();
      obs_t e;
      repeat (20) @(negedge clk);
      e = '0; e.rd_addr = 6'd63; e.stage = 3'd7; e.wr_addr = 6'd63;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL idle_hold got=%h exp=%h", obs, e); end
   endtask

   task automatic test_start_held();
      obs_t e;
      run_xfer("held_first", 6'd63, 1'b1, FULL);
      @(negedge clk);
      e = '0; e.rd_addr = 6'd63; e.stage = 3'd7; e.wr_addr = 6'd63;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL start_in_done_cycle got=%h exp=%h", obs, e); end
      run_xfer("held_second", 6'd63, 1'b0, FULL);
   endtask

   task automatic test_rst_abort();
      repeat (5) @(negedge clk);
      run_xfer("abort", 6'd63, 1'b0, 3 * PERIOD + 20 + 1);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL abort_reset got=%h exp=0", obs); end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== '0) begin errors++; $display("FAIL abort_quiet i=%0d got=%h exp=0", i, obs); end
      end
      run_xfer("restart", 6'd0, 1'b0, FULL);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      test_reset();
      run_xfer("single", 6'd0, 1'b0, FULL);
      test_idle_hold();
      test_start_held();
      test_rst_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
